tm1637_hex_n: RTL and testbench

- Parametrised TM1637 display driver: renders N hex nibbles plus per-digit decimal points on an N-digit TM1637 module.
- Adds programmable brightness/on-off, optional leading-zero blanking, ACK checking and a one-deep pending-update buffer.
- Sits between application logic (latch-style input) and the top-level open-drain CLK/DIO pads.

---
 rtl/tm1637_pkg.sv | 40 ++++
 rtl/tm1637_byte_tx.sv | 102 ++++++++++
 rtl/tm1637_hex_n.sv | 158 +++++++++++++++
 tb/tb_tm1637_hex_n.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1637_pkg.sv
// Shared constants, state encodings and the hex-to-segment table for the
// TM1637 display driver.
package tm1637_pkg;

    localparam logic [7:0] CMD_DATA = 8'h40;  // auto-increment data write
    localparam logic [7:0] CMD_ADDR = 8'hC0;  // address of the leftmost digit
    localparam logic [7:0] CMD_DISP = 8'h80;  // display control base

    // Serialiser phases; PH_NEXT names the sequencer's byte/phase selection step
    typedef enum logic [2:0] {PH_IDLE, PH_START, PH_BYTE, PH_ACK, PH_STOP, PH_NEXT} phase_t;

    // Top-level sequencer: issue one op (NEXT), then wait for it (WAIT)
    typedef enum logic [1:0] {SQ_IDLE, SQ_NEXT, SQ_WAIT} seq_t;

    // Index of the operation within one frame (at most 9 + 6 ops)
    typedef logic [3:0] step_t;

    // Segment pattern gfedcba for one hex nibble
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/tm1637_byte_tx.sv
// Line-level serialiser: one START, one byte plus ACK, or one STOP per request.
// Lines only move on ticks; op_done pulses on the tick that finishes the op.
module tm1637_byte_tx
    import tm1637_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       op_start,
    input  phase_t     op,
    input  logic [7:0] op_byte,
    input  logic       sda_in,
    output logic       op_done,
    output logic       ack_fail,
    output logic       scl_out,
    output logic       sda_en,
    output logic       sda_out
);

    phase_t     state, state_nx;
    logic [1:0] qcnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    logic       scl_nx, sda_nx, en_nx;

    // State, quarter-bit/bit counters and registered line levels
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= PH_IDLE;
            qcnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            scl_out <= 1'b1;
            sda_out <= 1'b1;
            sda_en  <= 1'b1;
        end else begin
            state   <= state_nx;
            scl_out <= scl_nx;
            sda_out <= sda_nx;
            sda_en  <= en_nx;
            if (state == PH_IDLE) begin
                qcnt <= '0;
                bcnt <= '0;
                if (op_start) shreg <= op_byte;
            end else if (tick) begin
                qcnt <= qcnt + 1'b1;
                if (state == PH_BYTE && qcnt == 2'd3) bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Phase transitions: byte runs 8 bits then its ACK slot
    always_comb begin
        state_nx = state;
        case (state)
            PH_IDLE:  if (op_start) state_nx = op;
            PH_START: if (tick && qcnt == 2'd1) state_nx = PH_IDLE;
            PH_BYTE:  if (tick && qcnt == 2'd3 && bcnt == 3'd7) state_nx = PH_ACK;
            PH_ACK:   if (tick && qcnt == 2'd3) state_nx = PH_IDLE;
            PH_STOP:  if (tick && qcnt == 2'd2) state_nx = PH_IDLE;
            default:  state_nx = PH_IDLE;
        endcase
    end

    // Next line levels per quarter-bit; SDA stays released after ACK until a bit drives it
    always_comb begin
        scl_nx   = scl_out;
        sda_nx   = sda_out;
        en_nx    = sda_en;
        op_done  = 1'b0;
        ack_fail = 1'b0;
        if (tick) begin
            case (state)
                PH_START: case (qcnt)
                    2'd0: begin scl_nx = 1'b1; sda_nx = 1'b1; en_nx = 1'b1; end
                    2'd1: begin sda_nx = 1'b0; op_done = 1'b1; end
                    default: ;
                endcase
                PH_BYTE: case (qcnt)
                    2'd0: scl_nx = 1'b0;
                    2'd1: begin en_nx = 1'b1; sda_nx = shreg[bcnt]; end
                    2'd2: scl_nx = 1'b1;
                    default: ;
                endcase
                PH_ACK: case (qcnt)
                    2'd0: scl_nx = 1'b0;
                    2'd1: en_nx = 1'b0;
                    2'd2: scl_nx = 1'b1;
                    default: begin op_done = 1'b1; ack_fail = sda_in; end
                endcase
                PH_STOP: case (qcnt)
                    2'd0: begin scl_nx = 1'b0; sda_nx = 1'b0; en_nx = 1'b1; end
                    2'd1: scl_nx = 1'b1;
                    2'd2: begin sda_nx = 1'b1; op_done = 1'b1; end
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tm1637_hex_n.sv
// N-digit TM1637 hex display driver: captures a display image, keeps one
// pending update, and sequences the data/address/control frames.
module tm1637_hex_n
    import tm1637_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 50,
    parameter int LZ_BLANK = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_latch,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [2:0]            bright_in,
    input  logic                  disp_on_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ack_err,
    output logic                  scl_en,
    output logic                  scl_out,
    output logic                  sda_en,
    output logic                  sda_out,
    input  logic                  sda_in
);

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   dp;
        logic [2:0]          bright;
        logic                disp_on;
    } disp_t;

    localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam step_t            LAST    = step_t'(8 + DIGITS);

    seq_t                   seq, seq_nx;
    step_t                  step;
    disp_t                  act, pend, cap;
    logic                   pend_vld, latch_q, lat_rise, tick;
    logic                   start_new, finish, reload;
    logic [DIV_W-1:0]       div_cnt;
    logic                   tx_start, tx_done, tx_fail;
    phase_t                 tx_op;
    logic [7:0]             tx_byte;
    logic [DIGITS-1:0][7:0] seg;

    assign cap       = '{data: data_in, dp: dp_in, bright: bright_in, disp_on: disp_on_in};
    assign lat_rise  = data_latch & ~latch_q;
    assign tick      = (seq != SQ_IDLE) && (div_cnt == DIV_MAX);
    assign start_new = (seq == SQ_IDLE) && lat_rise;
    assign finish    = (seq == SQ_WAIT) && tx_done && (step == LAST);
    // A request arriving on the finishing cycle is honoured without a detour through IDLE
    assign reload    = finish && (pend_vld || lat_rise);
    assign busy      = (seq != SQ_IDLE);
    assign scl_en    = 1'b1;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!rst) seq <= SQ_IDLE;
        else      seq <= seq_nx;
    end

    // Sequencer: issue one op, wait for it, then next op / restart / idle
    always_comb begin
        seq_nx = seq;
        case (seq)
            SQ_IDLE: if (lat_rise) seq_nx = SQ_NEXT;
            SQ_NEXT: seq_nx = SQ_WAIT;
            SQ_WAIT: if (tx_done) seq_nx = (finish && !reload) ? SQ_IDLE : SQ_NEXT;
            default: seq_nx = SQ_IDLE;
        endcase
    end

    // Capture, pending buffer, tick divider, frame step and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            latch_q  <= 1'b0;
            div_cnt  <= '0;
            step     <= '0;
            act      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            ack_err  <= 1'b0;
            done     <= 1'b0;
        end else begin
            latch_q <= data_latch;
            done    <= finish;
            div_cnt <= (seq == SQ_IDLE || div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
            if (tx_fail) ack_err <= 1'b1;
            if (start_new || reload) begin
                act     <= (reload && pend_vld) ? pend : cap;
                step    <= '0;
                ack_err <= 1'b0;
            end else if (seq == SQ_WAIT && tx_done) begin
                step <= step + 1'b1;
            end
            // Latest request wins; one consumed directly at the finish is not re-queued
            if (lat_rise && seq != SQ_IDLE && !(finish && !pend_vld)) begin
                pend     <= cap;
                pend_vld <= 1'b1;
            end else if (reload) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Segment bytes per nibble with optional leading-zero blanking (rightmost never blanked)
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        seg      = '0;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            run_zero = run_zero && (act.data[4*j +: 4] == 4'h0);
            if (LZ_BLANK != 0 && j != 0 && run_zero)
                seg[j] = {act.dp[j], 7'h00};
            else
                seg[j] = {act.dp[j], hex_seg(act.data[4*j +: 4])};
        end
    end

    // Op selection for the current step of the three-frame sequence
    always_comb begin
        tx_start = (seq == SQ_NEXT);
        tx_op    = PH_BYTE;
        tx_byte  = 8'h00;
        if (step == step_t'(0) || step == step_t'(3) || step == step_t'(6 + DIGITS))
            tx_op = PH_START;
        else if (step == step_t'(2) || step == step_t'(5 + DIGITS) || step == LAST)
            tx_op = PH_STOP;
        else if (step == step_t'(1))
            tx_byte = CMD_DATA;
        else if (step == step_t'(4))
            tx_byte = CMD_ADDR;
        else if (step == step_t'(7 + DIGITS))
            tx_byte = CMD_DISP | {4'b0000, act.disp_on, act.bright};
        else
            for (int k = 0; k < DIGITS; k++)
                if (step == step_t'(5 + k)) tx_byte = seg[DIGITS-1-k];
    end

    tm1637_byte_tx u_tx (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .op_start (tx_start),
        .op       (tx_op),
        .op_byte  (tx_byte),
        .sda_in   (sda_in),
        .op_done  (tx_done),
        .ack_fail (tx_fail),
        .scl_out  (scl_out),
        .sda_en   (sda_en),
        .sda_out  (sda_out)
    );

endmodule

// File: tb/tb_tm1637_hex_n.sv
// Bench for tm1637_hex_n: two instances (LZ_BLANK 0 and 1) share stimulus; a
// bus decoder turns each instance's pins into START/byte/STOP events which are
// compared with frames computed from the display rules.
module tb_tm1637_hex_n;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int EV_S    = 256;
    localparam int EV_P    = 257;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_latch = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [2:0]  bright_in = '0;
    logic        disp_on_in = 1'b0;
    logic        busy[2], done[2], ack_err[2], scl_en[2], scl_out[2];
    logic        sda_en[2], sda_out[2], sda_in[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tm1637_hex_n #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .LZ_BLANK(g)) u_dut (
            .clk(clk), .rst(rst), .data_latch(data_latch), .data_in(data_in),
            .dp_in(dp_in), .bright_in(bright_in), .disp_on_in(disp_on_in),
            .busy(busy[g]), .done(done[g]), .ack_err(ack_err[g]),
            .scl_en(scl_en[g]), .scl_out(scl_out[g]), .sda_en(sda_en[g]),
            .sda_out(sda_out[g]), .sda_in(sda_in[g])
        );
    end

    int   tests = 0;
    int   fails = 0;
    int   evq0[$], evq1[$];
    int   exp0[$], exp1[$];
    int   b0, b1;
    int   done_cnt[2];
    int   nb[2];
    logic [7:0] sh[2];
    logic pscl[2], psda[2];
    bit   inject = 1'b0;
    int   seg_tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                          'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    // Bus decoder and slave: pins read as pulled high when released
    always @(negedge clk) begin
        logic c, d;
        int   ev;
        for (int i = 0; i < 2; i++) begin
            c  = scl_en[i] ? scl_out[i] : 1'b1;
            d  = sda_en[i] ? sda_out[i] : 1'b1;
            ev = -1;
            if (done[i]) done_cnt[i]++;
            if (!rst) begin
                nb[i] = 0;
                sda_in[i] = 1'b0;
            end else if (pscl[i] && c && psda[i] && !d) begin
                ev = EV_S;
                nb[i] = 0;
            end else if (pscl[i] && c && !psda[i] && d) begin
                ev = EV_P;
            end else if (!pscl[i] && c) begin
                if (nb[i] < 8) sh[i][nb[i]] = d;
                nb[i]++;
                if (nb[i] == 8) begin
                    ev = int'(sh[i]);
                    if (inject && sh[i] == 8'hC0) sda_in[i] = 1'b1;
                end
                if (nb[i] == 9) nb[i] = 0;
            end else if (pscl[i] && !c && nb[i] == 0) begin
                sda_in[i] = 1'b0;
            end
            if (ev >= 0) begin
                if (i == 0) evq0.push_back(ev);
                else        evq1.push_back(ev);
            end
            pscl[i] = c;
            psda[i] = d;
        end
    end

    task automatic chk(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected segment byte for digit k (0 = leftmost) from the display rules
    function automatic int seg_exp(int lz, int data, int dp, int k);
        int n, lead;
        n    = (data >> (4 * (3 - k))) & 15;
        lead = 1;
        for (int j = 0; j <= k; j++)
            if (((data >> (4 * (3 - j))) & 15) != 0) lead = 0;
        return ((lz != 0 && k < 3 && lead != 0) ? 0 : seg_tab[n]) | (((dp >> (3 - k)) & 1) << 7);
    endfunction

    task automatic push_both(int v);
        exp0.push_back(v);
        exp1.push_back(v);
    endtask

    task automatic add_frame(int data, int dp, int br, int on);
        push_both(EV_S); push_both('h40); push_both(EV_P);
        push_both(EV_S); push_both('hC0);
        for (int k = 0; k < 4; k++) begin
            exp0.push_back(seg_exp(0, data, dp, k));
            exp1.push_back(seg_exp(1, data, dp, k));
        end
        push_both(EV_P);
        push_both(EV_S); push_both('h80 | (on << 3) | br); push_both(EV_P);
    endtask

    task automatic mark();
        b0 = evq0.size();
        b1 = evq1.size();
        exp0.delete();
        exp1.delete();
    endtask

    task automatic check_events(string tag);
        chk({tag, "_len0"}, evq0.size() - b0, exp0.size());
        chk({tag, "_len1"}, evq1.size() - b1, exp1.size());
        for (int k = 0; k < exp0.size(); k++)
            if (b0 + k < evq0.size()) chk($sformatf("%s_lz0_ev%0d", tag, k), evq0[b0+k], exp0[k]);
        for (int k = 0; k < exp1.size(); k++)
            if (b1 + k < evq1.size()) chk($sformatf("%s_lz1_ev%0d", tag, k), evq1[b1+k], exp1[k]);
    endtask

    task automatic latch(int data, int dp, int br, int on);
        data_in    = 16'(data);
        dp_in      = 4'(dp);
        bright_in  = 3'(br);
        disp_on_in = 1'(on);
        data_latch = 1'b1;
        @(posedge clk); #1;
        data_latch = 1'b0;
    endtask

    task automatic run_frame(int data, int dp, int br, int on, string tag);
        int t0, t1, n;
        mark();
        add_frame(data, dp, br, on);
        t0 = done_cnt[0];
        t1 = done_cnt[1];
        for (int i = 0; i < 2; i++) chk($sformatf("%s_busy_pre%0d", tag, i), int'(busy[i]), 0);
        latch(data, dp, br, on);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_busy_rise%0d", tag, i), int'(busy[i]), 1);
            chk($sformatf("%s_ackclr%0d", tag, i), int'(ack_err[i]), 0);
        end
        n = 0;
        while ((done_cnt[0] <= t0 || done_cnt[1] <= t1) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_timeout"}, int'(n < 5000), 1);
        repeat (10) @(posedge clk);
        #1;
        chk({tag, "_done0"}, done_cnt[0] - t0, 1);
        chk({tag, "_done1"}, done_cnt[1] - t1, 1);
        for (int i = 0; i < 2; i++) chk($sformatf("%s_busy_end%0d", tag, i), int'(busy[i]), 0);
        check_events(tag);
    endtask

    initial begin
        int t0, nd, n, data;
        bit dropped;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_scl_en%0d", i), int'(scl_en[i]), 1);
            chk($sformatf("rst_scl_out%0d", i), int'(scl_out[i]), 1);
            chk($sformatf("rst_sda_en%0d", i), int'(sda_en[i]), 1);
            chk($sformatf("rst_sda_out%0d", i), int'(sda_out[i]), 1);
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_done%0d", i), int'(done[i]), 0);
            chk($sformatf("rst_ack_err%0d", i), int'(ack_err[i]), 0);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame('hBEEF, 0, 7, 1, "basic");

        // Pending update mid-frame: second frame follows with busy held high
        mark();
        add_frame('hDEAF, 0, 3, 1);
        add_frame('hFEED, 'hA, 5, 0);
        t0 = done_cnt[0];
        latch('hDEAF, 0, 3, 1);
        repeat (300) @(posedge clk);
        #1;
        latch('hFEED, 'hA, 5, 0);
        nd = 0; n = 0; dropped = 1'b0;
        while (nd < 2 && n < 8000) begin
            @(posedge clk); #1;
            n++;
            if (done[0]) nd++;
            if (nd < 2 && !busy[0]) dropped = 1'b1;
        end
        chk("pend_timeout", int'(n < 8000), 1);
        chk("pend_busy_held", int'(dropped), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("pend_done_cnt", done_cnt[0] - t0, 2);
        chk("pend_busy_end", int'(busy[0]), 0);
        check_events("pend");

        run_frame('h0070, 'h1, 2, 1, "blank70");
        run_frame('h0000, 'h0, 0, 1, "blank00");

        for (int r = 0; r < 3; r++) begin
            data = int'($urandom_range(0, 65535)) >> (4 * $urandom_range(0, 3));
            run_frame(data, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        // Missing ACK on the address byte; frame still completes
        inject = 1'b1;
        run_frame('h1234, 'h3, 4, 1, "ackbad");
        inject = 1'b0;
        for (int i = 0; i < 2; i++) chk($sformatf("ack_err_set%0d", i), int'(ack_err[i]), 1);
        run_frame('h5678, 'h0, 6, 1, "ackgood");
        for (int i = 0; i < 2; i++) chk($sformatf("ack_err_clr%0d", i), int'(ack_err[i]), 0);

        // Reset during the data bytes with an update pending
        latch('h5A5A, 0, 1, 1);
        repeat (400) @(posedge clk);
        #1;
        latch('h1111, 0, 1, 1);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mrst_scl%0d", i), int'(scl_en[i] && scl_out[i]), 1);
            chk($sformatf("mrst_sda%0d", i), int'(sda_en[i] && sda_out[i]), 1);
            chk($sformatf("mrst_busy%0d", i), int'(busy[i]), 0);
        end
        rst = 1'b1;
        t0 = done_cnt[0];
        repeat (2500) @(posedge clk);
        #1;
        chk("mrst_no_done", done_cnt[0] - t0, 0);
        chk("mrst_idle", int'(busy[0] || busy[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
